// File: rtl/fetch_pc_gen_pkg.sv
// Shared constants and helpers for the fetch PC generator.
package fetch_pc_gen_pkg;

  localparam int PC_W_DEF    = 64;
  localparam int N_REDIR_DEF = 2;

  // Width of a redirect source index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch-side bus: stall/flush control, predicted PC, redirect sources and PC outputs.
interface fetch_pc_gen_if #(
  parameter int PC_W    = 64,
  parameter int N_REDIR = 2
);

  logic                      F_stall_i;
  logic                      F_flush_i;
  logic [PC_W-1:0]           f_pred_pc_i;
  logic [N_REDIR-1:0]        redir_valid_i;
  logic [N_REDIR*PC_W-1:0]   redir_pc_i;
  logic [PC_W-1:0]           F_pred_pc_o;
  logic                      F_redir_o;
  logic                      F_pend_o;

  // Fetch control / redirect producers.
  modport master (
    output F_stall_i, F_flush_i, f_pred_pc_i, redir_valid_i, redir_pc_i,
    input  F_pred_pc_o, F_redir_o, F_pend_o
  );

  // PC generator.
  modport slave (
    input  F_stall_i, F_flush_i, f_pred_pc_i, redir_valid_i, redir_pc_i,
    output F_pred_pc_o, F_redir_o, F_pend_o
  );

endinterface

// File: rtl/fetch_pc_gen_redir_prio_sel.sv
// Fixed-priority redirect selector: lowest set index wins.
module redir_prio_sel
  import fetch_pc_gen_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int N_REDIR = N_REDIR_DEF,
  parameter int IDX_W   = idx_w(N_REDIR)
) (
  input  logic [N_REDIR-1:0]      valid_i,
  input  logic [N_REDIR*PC_W-1:0] pc_i,
  output logic                    valid_o,
  output logic [IDX_W-1:0]        idx_o,
  output logic [PC_W-1:0]         pc_o
);

  // Scan from the lowest-priority source upward so index 0 is assigned last and wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    pc_o    = '0;
    for (int k = N_REDIR - 1; k >= 0; k--) begin
      if (valid_i[k]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(k);
        pc_o    = pc_i[k*PC_W +: PC_W];
      end
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC register: prioritised redirects, stall hold, and a one-entry
// pending buffer so a redirect arriving under stall is applied afterwards.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              N_REDIR  = N_REDIR_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  fetch_pc_gen_if.slave  bus
);

  localparam int IDX_W = idx_w(N_REDIR);

  logic             live_vld;
  logic [IDX_W-1:0] live_idx;
  logic [PC_W-1:0]  live_pc;

  logic [PC_W-1:0]  pc_q;
  logic             redir_q;
  logic             pend_valid;
  logic [IDX_W-1:0] pend_src;
  logic [PC_W-1:0]  pend_pc;
  logic             pend_live;
  logic             capture;

  redir_prio_sel #(
    .PC_W    (PC_W),
    .N_REDIR (N_REDIR),
    .IDX_W   (IDX_W)
  ) u_sel (
    .valid_i (bus.redir_valid_i),
    .pc_i    (bus.redir_pc_i),
    .valid_o (live_vld),
    .idx_o   (live_idx),
    .pc_o    (live_pc)
  );

  // A flushed entry is dead this cycle: it neither selects nor blocks a capture.
  assign pend_live = pend_valid && !bus.F_flush_i;
  assign capture   = live_vld && (!pend_live || (live_idx <= pend_src));

  // PC, redirect flag and pending-redirect buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      redir_q    <= 1'b0;
      pend_valid <= 1'b0;
      pend_src   <= '0;
      pend_pc    <= '0;
    end else if (!bus.F_stall_i) begin
      if (live_vld) begin
        pc_q    <= live_pc;
        redir_q <= 1'b1;
      end else if (pend_live) begin
        pc_q    <= pend_pc;
        redir_q <= 1'b1;
      end else begin
        pc_q    <= bus.f_pred_pc_i;
        redir_q <= 1'b0;
      end
      pend_valid <= 1'b0;
    end else begin
      if (capture) begin
        pend_valid <= 1'b1;
        pend_src   <= live_idx;
        pend_pc    <= live_pc;
      end else if (bus.F_flush_i) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign bus.F_pred_pc_o = pc_q;
  assign bus.F_redir_o   = redir_q;
  assign bus.F_pend_o    = pend_valid;

endmodule
